// File: rtl/gates_rr_sched.sv
// Round-robin scheduler sharing one gate-logic datapath among NREQ requesters.
// The winner's operands are captured into a valid/ready result slot.
module gates_rr_sched #(
   parameter  int NREQ = 4,
   parameter  int W    = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] req_va,
   input  logic [NREQ*W-1:0] req_vb,
   input  logic [NREQ*4-1:0] req_abcd,
   output logic [NREQ-1:0]   grant,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDW-1:0]    res_id,
   output logic              res_y,
   output logic [W-1:0]      res_vy
);

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [IDW-1:0]  w_win;
   logic            w_found;
   logic            w_issue;
   logic [W-1:0]    w_va;
   logic [W-1:0]    w_vb;
   logic [3:0]      w_abcd;
   logic            w_y;
   logic [NREQ-1:0] w_grant_nxt;
   logic [NREQ-1:0] r_grant;
   logic [IDW-1:0]  r_id;
   logic            r_y;
   logic [W-1:0]    r_vy;

   // winner search from ptr with wrap, then operand mux of the winner
   always_comb begin
      w_found = |req;
      w_win   = '0;
      // lowest requester overall covers the wrapped part of the search
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_win = IDW'(i);
         end
      end
      // lowest requester at or above ptr takes precedence
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i] && (IDW'(i) >= r_ptr)) begin
            w_win = IDW'(i);
         end
      end
      w_va   = '0;
      w_vb   = '0;
      w_abcd = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win == IDW'(i)) begin
            w_va   = req_va[i*W +: W];
            w_vb   = req_vb[i*W +: W];
            w_abcd = req_abcd[i*4 +: 4];
         end
      end
      w_y = (w_abcd[3] & w_abcd[2]) | ~(w_abcd[1] & w_abcd[0]);
      if (w_win == IDW'(NREQ - 1)) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_win + 1'b1;
      end
   end

   // slot next-state and issue decision
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = w_found && ((r_state == IDLE) || res_ready);
      w_grant_nxt = '0;
      if (w_issue) begin
         w_state_nxt = FULL;
         for (int i = 0; i < NREQ; i++) begin
            w_grant_nxt[i] = (w_win == IDW'(i));
         end
      end else if ((r_state == FULL) && res_ready) begin
         w_state_nxt = IDLE;
      end
   end

   // slot state, pointer and grant pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         if (w_issue) begin
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   // result registers load only on issue and otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id <= '0;
         r_y  <= 1'b0;
         r_vy <= '0;
      end else if (w_issue) begin
         r_id <= w_win;
         r_y  <= w_y;
         r_vy <= w_va & w_vb;
      end
   end

   assign grant     = r_grant;
   assign res_valid = (r_state == FULL);
   assign res_id    = r_id;
   assign res_y     = r_y;
   assign res_vy    = r_vy;

endmodule

// File: tb/tb_gates_rr_sched.sv
// Self-checking bench for gates_rr_sched: directed steps plus random traffic
// checked against a behavioural reference model of the scheduler.
module tb_gates_rr_sched;

   localparam int NREQ = 4;
   localparam int W    = 4;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_va;
   logic [NREQ*W-1:0] req_vb;
   logic [NREQ*4-1:0] req_abcd;
   logic [NREQ-1:0]   grant;
   logic              res_valid;
   logic              res_ready;
   logic [1:0]        res_id;
   logic              res_y;
   logic [W-1:0]      res_vy;

   int checks   = 0;
   int failures = 0;

   int         m_ptr;
   bit         m_valid;
   int         m_id;
   bit         m_y;
   logic [3:0] m_vy;
   logic [3:0] m_grant;

   gates_rr_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_va   (req_va),
      .req_vb   (req_vb),
      .req_abcd (req_abcd),
      .grant    (grant),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_id   (res_id),
      .res_y    (res_y),
      .res_vy   (res_vy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 0;
      m_id    = 0;
      m_y     = 0;
      m_vy    = '0;
      m_grant = '0;
   endtask

   // what the scheduler must do at the coming rising edge
   task automatic model_edge();
      int  w;
      bit  a, b, c, d;
      w = -1;
      if ((!m_valid || res_ready) && (req != '0)) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && req[idx]) w = idx;
         end
         a       = req_abcd[w*4+3];
         b       = req_abcd[w*4+2];
         c       = req_abcd[w*4+1];
         d       = req_abcd[w*4+0];
         m_y     = (a && b) || !(c && d);
         m_vy    = req_va[w*W +: W] & req_vb[w*W +: W];
         m_id    = w;
         m_valid = 1;
         m_grant = 4'(1 << w);
         m_ptr   = (w + 1) % NREQ;
      end else begin
         m_grant = '0;
         if (m_valid && res_ready) m_valid = 0;
      end
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, ".grant"}, 32'(grant), 32'(m_grant));
      chk({tag, ".valid"}, 32'(res_valid), 32'(m_valid));
      chk({tag, ".id"}, 32'(res_id), 32'(m_id));
      chk({tag, ".y"}, 32'(res_y), 32'(m_y));
      chk({tag, ".vy"}, 32'(res_vy), 32'(m_vy));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      cmp_all(tag);
   endtask

   task automatic set_op(input int i, input logic [3:0] va,
                         input logic [3:0] vb, input logic [3:0] abcd);
      req_va[i*W +: W]  = va;
      req_vb[i*W +: W]  = vb;
      req_abcd[i*4 +: 4] = abcd;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         set_op(i, 4'($urandom), 4'($urandom), 4'($urandom));
      end
   endtask

   logic [3:0] rot_exp [5];

   initial begin
      rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_n     = 1'b0;
      req       = '0;
      req_va    = '0;
      req_vb    = '0;
      req_abcd  = '0;
      res_ready = 1'b0;
      model_reset();
      #12;
      cmp_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // rotation with all requesters active
      req       = 4'b1111;
      res_ready = 1'b1;
      rand_ops();
      for (int n = 0; n < 5; n++) begin
         step("rot");
         chk("rot.grant_seq", 32'(grant), 32'(rot_exp[n]));
         chk("rot.id_seq", 32'(res_id), n % 4);
         chk("rot.valid", 32'(res_valid), 1);
      end

      // single operation on requester 0
      req = 4'b0001;
      set_op(0, 4'b1100, 4'b1010, 4'b1100);
      step("single");
      chk("single.grant", 32'(grant), 32'(4'b0001));
      chk("single.vy", 32'(res_vy), 32'(4'b1000));
      chk("single.y", 32'(res_y), 1);
      chk("single.id", 32'(res_id), 0);
      set_op(0, 4'b1100, 4'b1010, 4'b0111);
      step("abcd0111");
      set_op(0, 4'b1100, 4'b1010, 4'b0011);
      step("abcd0011");
      chk("abcd0011.y", 32'(res_y), 0);

      // drain to empty
      req = '0;
      step("drain");
      chk("drain.valid", 32'(res_valid), 0);
      step("drain2");
      chk("drain2.grant", 32'(grant), 0);

      // backpressure: one grant only while the slot is held
      req       = 4'b0110;
      res_ready = 1'b0;
      rand_ops();
      step("bp");
      chk("bp.grant", 32'(grant), 32'(4'b0010));
      for (int n = 0; n < 5; n++) begin
         step("bp_hold");
         chk("bp_hold.grant", 32'(grant), 0);
         chk("bp_hold.valid", 32'(res_valid), 1);
      end
      res_ready = 1'b1;
      step("bp_rel");
      chk("bp_rel.grant", 32'(grant), 32'(4'b0100));
      req = '0;
      step("bp_drain");

      // skip idle requesters around the wrap
      req = 4'b0001;
      step("skip_pre");
      req = 4'b1001;
      rand_ops();
      step("skip1");
      chk("skip1.grant", 32'(grant), 32'(4'b1000));
      step("skip2");
      chk("skip2.grant", 32'(grant), 32'(4'b0001));
      req = '0;
      step("skip_drain");

      // asynchronous reset while the slot is full
      req       = 4'b0100;
      res_ready = 1'b0;
      rand_ops();
      step("pre_rst");
      chk("pre_rst.grant", 32'(grant), 32'(4'b0100));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst.valid", 32'(res_valid), 0);
      chk("rst.grant", 32'(grant), 0);
      chk("rst.id", 32'(res_id), 0);
      chk("rst.y", 32'(res_y), 0);
      chk("rst.vy", 32'(res_vy), 0);
      model_reset();
      @(negedge clk);
      rst_n     = 1'b1;
      req       = 4'b1100;
      res_ready = 1'b1;
      step("post_rst");
      chk("post_rst.grant", 32'(grant), 32'(4'b0100));

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         req       = 4'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         rand_ops();
         step("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
